ahblite_led_seq: RTL and testbench

AHBLITE_LED_SEQ -- requirements
Module: ahblite_led_seq

---
 rtl/ahblite_led_seq_pkg.sv | 28 ++
 rtl/led_tick_div.sv | 32 +++
 rtl/ahblite_led_seq.sv | 156 +++++++++++++++
 tb/tb_ahblite_led_seq.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahblite_led_seq_pkg.sv
// Shared definitions for the AHB-Lite LED sequencer: mode encodings,
// register word offsets (HADDR[3:2]) and the mode indicator decode.
package ahblite_led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_ROT_L  = 2'd1,
    MODE_ROT_R  = 2'd2,
    MODE_BLINK  = 2'd3
  } led_mode_t;

  localparam logic [1:0] REG_CTRL    = 2'd0;  // byte offset 0x0
  localparam logic [1:0] REG_DIV     = 2'd1;  // byte offset 0x4
  localparam logic [1:0] REG_PATTERN = 2'd2;  // byte offset 0x8
  localparam logic [1:0] REG_STATUS  = 2'd3;  // byte offset 0xC

  function automatic logic [3:0] mode_onehot(input led_mode_t m);
    logic [3:0] oh;
    case (m)
      MODE_MANUAL: oh = 4'b0001;
      MODE_ROT_L:  oh = 4'b0010;
      MODE_ROT_R:  oh = 4'b0100;
      default:     oh = 4'b1000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/led_tick_div.sv
// Prescaler for the LED sequencer: down-counter that ticks once every
// (div + 1) cycles while running, held at div while stopped.
module led_tick_div #(
  parameter int               DIV_W   = 24,
  parameter logic [DIV_W-1:0] RST_DIV = 24'd5_000_000
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             run,
  input  logic             reload,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] tcnt;

  // A forced reload swallows the tick that would otherwise fire this cycle.
  assign tick = run & ~reload & (tcnt == '0);

  // Count down; reload from div on tick, forced reload, or while stopped.
  // div is only sampled at reload, so a new value never disturbs a count in progress.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      tcnt <= RST_DIV;
    end else if (reload | ~run | tick) begin
      tcnt <= div;
    end else begin
      tcnt <= tcnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/ahblite_led_seq.sv
// AHB-Lite slave driving an 8-bit LED sequencer with four registers
// (CTRL, DIV, PATTERN, STATUS). LED follows register writes one cycle
// after the registers themselves change.
module ahblite_led_seq
  import ahblite_led_seq_pkg::*;
#(
  parameter int               DIV_W   = 24,
  parameter logic [DIV_W-1:0] RST_DIV = 24'd5_000_000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic [7:0]  LED,
  output logic [3:0]  signal_LED
);

  logic [1:0]       addr_p1;
  logic             wr_p1;
  logic             pat_ld_p2;
  logic             ctrl_ld_p2;
  logic             en_q;
  led_mode_t        mode_q;
  logic [DIV_W-1:0] div_q;
  logic [7:0]       pattern_q;
  logic [7:0]       led_q;
  logic [7:0]       step_q;
  logic             xfer;
  logic             we;
  logic             ctrl_chg;
  logic             run;
  logic             tick;
  logic             unused_bus;

  function automatic logic [7:0] rotl8(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  function automatic logic [7:0] rotr8(input logic [7:0] v);
    return {v[0], v[7:1]};
  endfunction

  assign HREADYOUT  = 1'b1;
  assign HRESP      = 1'b0;
  assign xfer       = HSEL & HREADY & HTRANS[1];
  assign we         = wr_p1 & HREADY;
  assign ctrl_chg   = (HWDATA[2:0] != {mode_q, en_q});
  assign run        = en_q & (mode_q != MODE_MANUAL);
  assign LED        = led_q;
  assign signal_LED = mode_onehot(mode_q);
  // Size/protection and unmapped address/data bits carry no meaning here.
  assign unused_bus = ^{HSIZE, HPROT, HADDR, HTRANS, HWDATA};

  // ---- address phase -> data phase (p1) ----
  // Capture the register index and write flag of an accepted transfer.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_p1 <= 2'd0;
      wr_p1   <= 1'b0;
    end else if (HREADY) begin
      wr_p1 <= xfer & HWRITE;
      if (xfer) begin
        addr_p1 <= HADDR[3:2];
      end
    end
  end

  // Commit write data into the register file at the end of the data phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      en_q      <= 1'b0;
      mode_q    <= MODE_MANUAL;
      div_q     <= RST_DIV;
      pattern_q <= 8'h01;
    end else if (we) begin
      case (addr_p1)
        REG_CTRL: begin
          en_q   <= HWDATA[0];
          mode_q <= led_mode_t'(HWDATA[2:1]);
        end
        REG_DIV:     div_q     <= HWDATA[DIV_W-1:0];
        REG_PATTERN: pattern_q <= HWDATA[7:0];
        default:     ;
      endcase
    end
  end

  // ---- register commit -> LED update (p2) ----
  // One-cycle load requests: new PATTERN, or CTRL write that changed EN/MODE.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pat_ld_p2  <= 1'b0;
      ctrl_ld_p2 <= 1'b0;
    end else begin
      pat_ld_p2  <= we & (addr_p1 == REG_PATTERN);
      ctrl_ld_p2 <= we & (addr_p1 == REG_CTRL) & ctrl_chg;
    end
  end

  led_tick_div #(
    .DIV_W   (DIV_W),
    .RST_DIV (RST_DIV)
  ) u_tick_div (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .run    (run),
    .reload (ctrl_ld_p2),
    .div    (div_q),
    .tick   (tick)
  );

  // Pattern engine: any load wins over the tick update; STEP counts ticks.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      led_q  <= 8'h01;
      step_q <= 8'h00;
    end else begin
      if (ctrl_ld_p2 | ~run | pat_ld_p2) begin
        led_q <= pattern_q;
      end else if (tick) begin
        case (mode_q)
          MODE_ROT_L: led_q <= rotl8(led_q);
          MODE_ROT_R: led_q <= rotr8(led_q);
          MODE_BLINK: led_q <= (led_q == 8'h00) ? pattern_q : 8'h00;
          default:    led_q <= pattern_q;
        endcase
      end
      if (ctrl_ld_p2) begin
        step_q <= 8'h00;
      end else if (tick) begin
        step_q <= step_q + 8'd1;
      end
    end
  end

  // Read mux keyed by the captured data-phase address.
  always_comb begin
    HRDATA = 32'h0;
    case (addr_p1)
      REG_CTRL:    HRDATA = {29'h0, mode_q, en_q};
      REG_DIV:     HRDATA = 32'(div_q);
      REG_PATTERN: HRDATA = {24'h0, pattern_q};
      default:     HRDATA = {16'h0, step_q, 7'h0, en_q};
    endcase
  end

endmodule

// File: tb/tb_ahblite_led_seq.sv
// Bench for ahblite_led_seq: directed scenarios plus randomized bus traffic,
// all compared every cycle against a behavioural model of the sequencer.
module tb_ahblite_led_seq;

  localparam logic [23:0] RST_DIV = 24'd7;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [7:0]  LED;
  logic [3:0]  signal_LED;

  always #5 HCLK = ~HCLK;

  ahblite_led_seq #(
    .DIV_W   (24),
    .RST_DIV (RST_DIV)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HSEL       (HSEL),
    .HWRITE     (HWRITE),
    .HREADY     (HREADY),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HSIZE      (HSIZE),
    .HPROT      (HPROT),
    .HWDATA     (HWDATA),
    .HREADYOUT  (HREADYOUT),
    .HRESP      (HRESP),
    .HRDATA     (HRDATA),
    .LED        (LED),
    .signal_LED (signal_LED)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (values after the most recent clock edge).
  logic        m_en;
  logic [1:0]  m_mode;
  logic [23:0] m_div;
  logic [7:0]  m_pat;
  logic [7:0]  m_led;
  logic [7:0]  m_step;
  logic        m_blink_off;
  logic        m_pat_pend;
  logic        m_ctrl_pend;
  logic [1:0]  m_addr;
  logic        m_wr;
  longint      m_cyc = 0;
  longint      m_next_tick = 0;

  logic [7:0]  last_led = 8'h00;
  longint      chg_q[$];
  logic [31:0] d;
  longint      t0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, m_cyc);
    end
  endtask

  function automatic logic [31:0] exp_rdata();
    case (m_addr)
      2'd0:    return {29'h0, m_mode, m_en};
      2'd1:    return {8'h0, m_div};
      2'd2:    return {24'h0, m_pat};
      default: return {16'h0, m_step, 7'h0, m_en};
    endcase
  endfunction

  // Advance the model across one clock edge using the inputs the DUT sampled.
  task automatic model_step();
    logic running;
    logic tick;
    logic we;
    logic new_pat;
    logic new_ctrl;
    if (HRESET) begin
      m_en = 1'b0; m_mode = 2'd0; m_div = RST_DIV; m_pat = 8'h01;
      m_led = 8'h01; m_step = 8'h00; m_blink_off = 1'b0;
      m_pat_pend = 1'b0; m_ctrl_pend = 1'b0; m_addr = 2'd0; m_wr = 1'b0;
    end else begin
      running  = m_en && (m_mode != 2'd0);
      tick     = running && !m_ctrl_pend && (m_cyc == m_next_tick);
      we       = m_wr && HREADY;
      new_pat  = we && (m_addr == 2'd2);
      new_ctrl = we && (m_addr == 2'd0) && (HWDATA[2:0] != {m_mode, m_en});
      if (m_ctrl_pend || !running || m_pat_pend) begin
        m_led = m_pat;
        m_blink_off = 1'b0;
      end else if (tick) begin
        if (m_mode == 2'd1) m_led = (m_led << 1) | (m_led >> 7);
        else if (m_mode == 2'd2) m_led = (m_led >> 1) | (m_led << 7);
        else begin
          m_blink_off = !m_blink_off;
          m_led = m_blink_off ? 8'h00 : m_pat;
        end
      end
      if (m_ctrl_pend) m_step = 8'h00;
      else if (tick) m_step = m_step + 8'd1;
      if ((m_ctrl_pend && running) || tick) m_next_tick = m_cyc + 1 + longint'(m_div);
      if (we) begin
        if (m_addr == 2'd0) begin m_en = HWDATA[0]; m_mode = HWDATA[2:1]; end
        else if (m_addr == 2'd1) m_div = HWDATA[23:0];
        else if (m_addr == 2'd2) m_pat = HWDATA[7:0];
      end
      m_pat_pend  = new_pat;
      m_ctrl_pend = new_ctrl;
      if (HREADY) begin
        m_wr = HSEL && HTRANS[1] && HWRITE;
        if (HSEL && HTRANS[1]) m_addr = HADDR[3:2];
      end
    end
    m_cyc++;
  endtask

  task automatic step();
    logic [3:0] exp_sig;
    @(posedge HCLK);
    #1;
    model_step();
    exp_sig = 4'b0001 << m_mode;
    chk("led", {24'h0, LED}, {24'h0, m_led});
    chk("signal_led", {28'h0, signal_LED}, {28'h0, exp_sig});
    chk("hrdata", HRDATA, exp_rdata());
    chk("hreadyout", {31'h0, HREADYOUT}, 32'h1);
    chk("hresp", {31'h0, HRESP}, 32'h0);
    if (LED !== last_led) chg_q.push_back(m_cyc);
    last_led = LED;
  endtask

  task automatic idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HREADY = 1'b1;
  endtask

  task automatic bus_write(input logic [3:0] off, input logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HREADY = 1'b1;
    HADDR = {$urandom_range(0, 15) << 28, 24'h0, off};
    HSIZE = 3'($urandom); HPROT = 4'($urandom);
    step();
    idle();
    HWDATA = data;
    step();
  endtask

  task automatic bus_read(input logic [3:0] off, output logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HREADY = 1'b1;
    HADDR = {28'h0, off};
    step();
    data = HRDATA;
    idle();
    step();
  endtask

  task automatic wait_led(input logic [7:0] v, input string tag);
    int n;
    n = 0;
    while (LED !== v && n < 200) begin
      step();
      n++;
    end
    chk(tag, {24'h0, LED}, {24'h0, v});
  endtask

  task automatic wait_chg(input int k, input string tag);
    int n;
    n = 0;
    while (chg_q.size() < k && n < 200) begin
      step();
      n++;
    end
    chk(tag, {31'h0, chg_q.size() >= k}, 32'h1);
  endtask

  initial begin
    HRESET = 1'b1; idle(); HADDR = 32'h0; HWDATA = 32'h0; HSIZE = 3'd2; HPROT = 4'd0;
    step();
    step();
    chk("rst_led", {24'h0, LED}, 32'h01);
    chk("rst_signal_led", {28'h0, signal_LED}, 32'h1);
    HRESET = 1'b0;
    bus_read(4'h0, d); chk("rst_ctrl", d, 32'h0);
    bus_read(4'h4, d); chk("rst_div", d, {8'h0, RST_DIV});
    bus_read(4'h8, d); chk("rst_pattern", d, 32'h1);
    bus_read(4'hC, d); chk("rst_status", d, 32'h0);

    // ROT_L with DIV=3: one step every 4 cycles, full circle after 8 ticks.
    bus_write(4'h4, 32'd3);
    bus_write(4'h0, 32'h3);
    wait_led(8'h02, "rotl_02");
    t0 = m_cyc;
    wait_led(8'h04, "rotl_04");
    chk("rotl_interval", 32'(m_cyc - t0), 32'd4);
    wait_led(8'h01, "rotl_wrap");
    bus_read(4'hC, d); chk("rotl_step8", d, 32'h0000_0801);

    // BLINK with DIV=0: toggles every cycle.
    bus_write(4'h4, 32'd0);
    bus_write(4'h8, 32'hA5);
    bus_write(4'h0, 32'h7);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("blink_led", {24'h0, LED}, (i % 2 == 0) ? 32'hA5 : 32'h00);
      chk("blink_signal_led", {28'h0, signal_LED}, 32'h8);
    end

    // ROT_R with DIV=2, DIV=9 written mid-count.
    bus_write(4'h0, 32'h0);
    bus_write(4'h8, 32'h01);
    bus_write(4'h4, 32'd2);
    bus_write(4'h0, 32'h5);
    step();
    step();
    chg_q.delete();
    wait_chg(1, "rotr_first_tick");
    bus_write(4'h4, 32'd9);
    wait_chg(3, "rotr_later_ticks");
    if (chg_q.size() >= 3) begin
      chk("rotr_cur_interval", 32'(chg_q[1] - chg_q[0]), 32'd3);
      chk("rotr_next_interval", 32'(chg_q[2] - chg_q[1]), 32'd10);
    end

    // PATTERN load landing on a tick, then switch to MANUAL.
    bus_write(4'h4, 32'd3);
    bus_write(4'h0, 32'h3);
    step();
    step();
    chg_q.delete();
    wait_chg(1, "pat_tick_sync");
    step();
    bus_write(4'h8, 32'h3C);
    step();
    chk("pat_on_tick", {24'h0, LED}, 32'h3C);
    repeat (4) step();
    chk("pat_then_rotate", {24'h0, LED}, 32'h78);
    bus_write(4'h0, 32'h1);
    step();
    chk("manual_led", {24'h0, LED}, 32'h3C);
    bus_read(4'hC, d); chk("manual_status", d, 32'h1);

    // Reset during the data phase of a PATTERN write while ROT_L runs.
    bus_write(4'h0, 32'h3);
    repeat (3) step();
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h8;
    step();
    idle();
    HWDATA = 32'hFF;
    HRESET = 1'b1;
    step();
    chk("midrst_led", {24'h0, LED}, 32'h01);
    chk("midrst_signal_led", {28'h0, signal_LED}, 32'h1);
    HRESET = 1'b0;
    step();
    bus_read(4'h8, d); chk("midrst_pattern", d, 32'h1);
    bus_read(4'h0, d); chk("midrst_ctrl", d, 32'h0);
    bus_read(4'h4, d); chk("midrst_div", d, {8'h0, RST_DIV});
    bus_read(4'hC, d); chk("midrst_status", d, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      int op;
      logic [3:0] off;
      logic [31:0] wd;
      op  = int'($urandom_range(0, 9));
      off = {2'($urandom_range(0, 3)), 2'b00};
      if (op <= 3) begin
        case (off)
          4'h0:    wd = {$urandom_range(0, 255) << 24, 21'h0, 3'($urandom)};
          4'h4:    wd = {8'($urandom), 24'($urandom_range(0, 5))};
          default: wd = $urandom;
        endcase
        bus_write(off, wd);
      end else if (op <= 6) begin
        bus_read(off, d);
      end else if (op <= 8) begin
        HSEL   = 1'($urandom);
        HWRITE = 1'($urandom);
        HREADY = 1'($urandom);
        HTRANS = HREADY ? {1'b0, 1'($urandom)} : 2'($urandom);
        HADDR  = $urandom;
        HWDATA = $urandom;
        step();
        idle();
      end else if ($urandom_range(0, 14) == 0) begin
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
